uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with majority-vote bit sampling,
// configurable framing, break detection and a show-ahead receive FIFO.
module uart_rx_cfg #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int BAUD_OS = BAUD_RATE * OVERSAMPLE;
    localparam int DIV_RAW = (CLOCK_FREQ + BAUD_OS / 2) / BAUD_OS;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = $clog2(DIV) + 1;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS) + 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int FW      = DATA_BITS + 2;

    localparam logic [TW-1:0] SMP0 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SMP1 = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] SMP2 = TW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_s, rx_prev;
    logic [2:0]           sync_ok;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, ferr, s0, s1;
    logic                 push;
    logic [FW-1:0]        wr_word;
    logic [FW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;

    logic fall, vote, mid, last_stop, brk_cond, perr_calc, data_par;
    logic frame_done, brk_hit;
    logic full, pop, wr_en;
    logic [FW-1:0] head;

    // Two-flop synchronizer plus a previous-value flop for edge detection.
    // sync_ok holds off edge detection until the reset-time 1s have drained,
    // so a line already low when reset releases cannot look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            sync_ok <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            sync_ok <= {sync_ok[1:0], 1'b1};
        end
    end

    // Free-running divider producing one oversample tick every DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
            tick    <= 1'b0;
        end
    end

    assign fall      = sync_ok[2] & rx_prev & ~rx_s;
    assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign mid       = tick && (tick_cnt == SMP2) &&
                       (state == START || state == DATA || state == PAR || state == STOP);
    assign last_stop = (STOP_BITS == 1) || (bit_cnt == BW'(1));
    assign data_par  = (^shreg) ^ par_bit;
    assign perr_calc = (PARITY == 1) ? ~data_par : (PARITY == 2) ? data_par : 1'b0;
    assign brk_cond  = (shreg == '0) && !par_bit && !vote && (bit_cnt == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; decisions are made at the third sample of each bit.
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        brk_hit    = 1'b0;
        case (state)
            IDLE:  if (fall) state_next = START;
            START: if (mid) state_next = vote ? IDLE : DATA;
            DATA:  if (mid && bit_cnt == BW'(DATA_BITS - 1))
                       state_next = (PARITY != 0) ? PAR : STOP;
            PAR:   if (mid) state_next = STOP;
            STOP:  if (mid) begin
                       if (brk_cond) begin
                           state_next = BRK;
                           brk_hit    = 1'b1;
                       end else if (last_stop) begin
                           state_next = IDLE;
                           frame_done = 1'b1;
                       end
                   end
            BRK:   if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit timing, sampling, shift register and per-frame error accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            ferr      <= 1'b0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            push      <= 1'b0;
            wr_word   <= '0;
            break_det <= 1'b0;
        end else begin
            push      <= frame_done;
            break_det <= brk_hit;
            if (frame_done) wr_word <= {shreg, perr_calc, ferr | ~vote};
            if (state == IDLE) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                par_bit  <= 1'b0;
                ferr     <= 1'b0;
            end else if (tick) begin
                tick_cnt <= (tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + TW'(1);
                if (tick_cnt == SMP0) s0 <= rx_s;
                if (tick_cnt == SMP1) s1 <= rx_s;
                if (mid) begin
                    case (state)
                        DATA: begin
                            shreg   <= {vote, shreg[DATA_BITS-1:1]};
                            bit_cnt <= (bit_cnt == BW'(DATA_BITS - 1)) ? '0 : bit_cnt + BW'(1);
                        end
                        PAR:  par_bit <= vote;
                        STOP: begin
                            ferr    <= ferr | ~vote;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = rx_valid && rx_ready;
    assign wr_en = push && (!full || pop);

    // FIFO storage; contents need no reset because the outputs are gated by rx_valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
    end

    // FIFO pointers, occupancy and overrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? head[FW-1:2] : '0;
    assign parity_err = rx_valid & head[1];
    assign frame_err  = rx_valid & head[0];
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance (lane 0) and an 8E1
// instance (lane 1), 16 clocks per bit.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
    logic ovr_a, ovr_b, brk_a, brk_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int vcyc_a = 0, vcyc_b = 0, brk_cnt_a = 0, ovr_cnt_a = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    typedef struct {
        int         lane;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
        .overrun(ovr_a), .break_det(brk_a), .busy(busy_a));

    uart_rx_cfg #(.CLOCK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b),
        .overrun(ovr_b), .break_det(brk_b), .busy(busy_b));

    // Record every accepted head entry and count pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_a) vcyc_a++;
            if (valid_b) vcyc_b++;
            if (valid_a && ready_a) q_a.push_back({data_a, perr_a, ferr_a});
            if (valid_b && ready_b) q_b.push_back({data_b, perr_b, ferr_b});
            if (brk_a) brk_cnt_a++;
            if (ovr_a) ovr_cnt_a++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int lane, input logic v);
        if (lane == 0) rx_a = v;
        else           rx_b = v;
    endtask

    task automatic send_bits(input int lane, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(lane, bits[i]);
            clks(16);
        end
        set_rx(lane, 1'b1);
    endtask

    task automatic send8n1(input logic [7:0] d);
        send_bits(0, {6'b0, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic pop_check(input string tag, input int lane, input logic [7:0] d,
                             input logic pe, input logic fe);
        logic [9:0] e;
        int sz;
        sz = (lane == 0) ? q_a.size() : q_b.size();
        if (sz == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            e = (lane == 0) ? q_a.pop_front() : q_b.pop_front();
            check({tag, "_data"}, e[9:2], d);
            check({tag, "_perr"}, e[1], pe);
            check({tag, "_ferr"}, e[0], fe);
        end
    endtask

    initial begin
        int va, vb, bk, ov;
        logic [15:0] fb;

        //            lane data   par   stop  exp    perr  ferr
        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[5] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[6] = '{1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[8] = '{1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};

        // Reset state
        clks(4);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_data", data_a, 0);
        check("rst_flags", {perr_a, ferr_a, ovr_a, brk_a}, 0);
        check("rst_valid_b", valid_b, 0);
        rst_n = 1'b1;
        clks(32);

        // Table-driven frames
        foreach (vecs[i]) begin
            va = vcyc_a;
            vb = vcyc_b;
            if (vecs[i].lane == 0) fb = {6'b0, vecs[i].stop, vecs[i].data, 1'b0};
            else                   fb = {5'b0, vecs[i].stop, vecs[i].par, vecs[i].data, 1'b0};
            send_bits(vecs[i].lane, fb, (vecs[i].lane == 0) ? 10 : 11);
            clks(32);
            check($sformatf("vec%0d_qsize", i), (vecs[i].lane == 0) ? q_a.size() : q_b.size(), 1);
            check($sformatf("vec%0d_vcyc", i),
                  (vecs[i].lane == 0) ? (vcyc_a - va) : (vcyc_b - vb), 1);
            pop_check($sformatf("vec%0d", i), vecs[i].lane, vecs[i].exp_data,
                      vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        // Break: 20 bit times low
        bk = brk_cnt_a;
        va = vcyc_a;
        rx_a = 1'b0;
        clks(320);
        check("brk_busy_low", busy_a, 1);
        check("brk_pulses", brk_cnt_a - bk, 1);
        check("brk_no_write", vcyc_a - va, 0);
        rx_a = 1'b1;
        clks(8);
        check("brk_busy_idle", busy_a, 0);
        clks(32);

        // Glitch on idle line: 3 clocks low
        va = vcyc_a;
        rx_a = 1'b0;
        clks(3);
        rx_a = 1'b1;
        clks(2);
        check("glitch_busy_start", busy_a, 1);
        clks(20);
        check("glitch_idle", busy_a, 0);
        check("glitch_no_write", vcyc_a - va, 0);
        clks(16);

        // 0xFF with a one-clock low spike at the centre of data bit 3
        rx_a = 1'b0;
        clks(16);
        for (int b = 0; b < 8; b++) begin
            if (b == 3) begin
                rx_a = 1'b1; clks(8);
                rx_a = 1'b0; clks(1);
                rx_a = 1'b1; clks(7);
            end else begin
                rx_a = 1'b1; clks(16);
            end
        end
        rx_a = 1'b1;
        clks(16 + 32);
        check("spike_qsize", q_a.size(), 1);
        pop_check("spike", 0, 8'hFF, 1'b0, 1'b0);

        // Overrun: consumer stalled, five frames into a depth-4 FIFO
        ready_a = 1'b0;
        ov = ovr_cnt_a;
        for (int k = 1; k <= 5; k++) begin
            send8n1(8'(k));
            clks(16);
            if (k == 4) check("ovr_before5", ovr_cnt_a - ov, 0);
        end
        check("ovr_at5", ovr_cnt_a - ov, 1);
        check("ovr_valid", valid_a, 1);
        check("ovr_head", data_a, 8'h01);
        ready_a = 1'b1;
        clks(10);
        check("ovr_qsize", q_a.size(), 4);
        for (int k = 1; k <= 4; k++) pop_check($sformatf("ovr_pop%0d", k), 0, 8'(k), 1'b0, 1'b0);
        check("ovr_empty", valid_a, 0);
        clks(16);

        // Reset in the middle of a frame, line held low across release
        bk = brk_cnt_a;
        rx_a = 1'b0;
        clks(16 * 5 + 4);
        check("mid_busy_before_rst", busy_a, 1);
        rst_n = 1'b0;
        clks(3);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_valid", valid_a, 0);
        rst_n = 1'b1;
        clks(40);
        check("mid_low_no_start", busy_a, 0);
        rx_a = 1'b1;
        clks(32);
        send8n1(8'h5A);
        clks(32);
        check("mid_qsize", q_a.size(), 1);
        pop_check("mid_5a", 0, 8'h5A, 1'b0, 1'b0);
        check("mid_no_break", brk_cnt_a - bk, 0);
        check("lane1_untouched", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
